// File: rtl/core_c1_biu_pkg.sv
// Shared types for the c1 BIU arbiter: FSM state encoding, transaction owner and a counter-width helper.
package core_c1_biu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // Bits needed to count 0..max_val inclusive.
    function automatic int cnt_width(int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/core_c1_biu_arb_if.sv
// Bundle of requester, memory-port and status signals of the c1 BIU arbiter.
// Signal prefixes are relative to the arbiter: i_* flow into it, o_* flow out of it.
interface core_c1_biu_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              i_flush;

    logic              i_if_req_valid;
    logic [AW-1:0]     i_if_req_addr;
    logic              o_if_req_ready;
    logic              o_if_rsp_valid;
    logic [DW-1:0]     o_if_rsp_data;

    logic              i_ls_req_valid;
    logic              i_ls_req_we;
    logic [AW-1:0]     i_ls_req_addr;
    logic [DW-1:0]     i_ls_req_wdata;
    logic [DW/8-1:0]   i_ls_req_wstrb;
    logic              o_ls_req_ready;
    logic              o_ls_rsp_valid;
    logic [DW-1:0]     o_ls_rsp_data;

    logic              o_mem_req_valid;
    logic              o_mem_req_we;
    logic [AW-1:0]     o_mem_req_addr;
    logic [DW-1:0]     o_mem_req_wdata;
    logic [DW/8-1:0]   o_mem_req_wstrb;
    logic              i_mem_req_ready;
    logic              i_mem_rsp_valid;
    logic [DW-1:0]     i_mem_rsp_data;

    logic              o_busy;

    // Arbiter side: it masters the single BIU memory port.
    modport master (
        input  i_flush,
        input  i_if_req_valid, i_if_req_addr,
        output o_if_req_ready, o_if_rsp_valid, o_if_rsp_data,
        input  i_ls_req_valid, i_ls_req_we, i_ls_req_addr, i_ls_req_wdata, i_ls_req_wstrb,
        output o_ls_req_ready, o_ls_rsp_valid, o_ls_rsp_data,
        output o_mem_req_valid, o_mem_req_we, o_mem_req_addr, o_mem_req_wdata, o_mem_req_wstrb,
        input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
        output o_busy
    );

    // Environment side: requesters plus the memory.
    modport slave (
        output i_flush,
        output i_if_req_valid, i_if_req_addr,
        input  o_if_req_ready, o_if_rsp_valid, o_if_rsp_data,
        output i_ls_req_valid, i_ls_req_we, i_ls_req_addr, i_ls_req_wdata, i_ls_req_wstrb,
        input  o_ls_req_ready, o_ls_rsp_valid, o_ls_rsp_data,
        input  o_mem_req_valid, o_mem_req_we, o_mem_req_addr, o_mem_req_wdata, o_mem_req_wstrb,
        output i_mem_req_ready, i_mem_rsp_valid, i_mem_rsp_data,
        input  o_busy
    );

endinterface

// File: rtl/core_c1_biu_arb_sel.sv
// Grant selection for the c1 BIU arbiter: fixed LS priority with IF anti-starvation counter,
// or round-robin when C1_BIU_ARB_RR_EN is defined.
module core_c1_biu_arb_sel
    import core_c1_biu_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic if_valid,
    input  logic ls_valid,
    output logic gnt_if,
    output logic gnt_ls
);

`ifdef C1_BIU_ARB_RR_EN
    owner_t last_owner;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        gnt_if = arb_en && if_valid && (last_owner == OWN_LS || !ls_valid);
        gnt_ls = arb_en && ls_valid && !gnt_if;
    end

    // Starts as if LS went last, so IF wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_owner <= OWN_LS;
        end else if (gnt_if) begin
            last_owner <= OWN_IF;
        end else if (gnt_ls) begin
            last_owner <= OWN_LS;
        end
    end
`else
    localparam int             CW      = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          force_if;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        force_if = if_valid && (starve_cnt == CNT_MAX);
        gnt_ls   = arb_en && ls_valid && !force_if;
        gnt_if   = arb_en && if_valid && !gnt_ls;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (gnt_if) begin
            starve_cnt <= '0;
        end else if (gnt_ls && if_valid && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`endif

endmodule

// File: rtl/core_c1_biu_arb.sv
// c1 core BIU arbiter: serialises IF and LS requests onto one memory port, one transaction at a time.
// Define C1_BIU_ARB_RR_EN for round-robin arbitration instead of LS priority with starvation guard.
module core_c1_biu_arb
    import core_c1_biu_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    core_c1_biu_arb_if.master bus
);

    state_t           state, state_nxt;
    owner_t           owner_r;
    logic             we_r;
    logic [AW-1:0]    addr_r;
    logic [DW-1:0]    wdata_r;
    logic [DW/8-1:0]  wstrb_r;
    logic             drop_r;

    logic             gnt_if, gnt_ls;
    logic             rsp_fire, if_rsp_d, ls_rsp_d;
    logic             if_rsp_valid_r, ls_rsp_valid_r;
    logic [DW-1:0]    if_rsp_data_r, ls_rsp_data_r;

    core_c1_biu_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .arb_en   (state == IDLE && rst_n),
        .if_valid (bus.i_if_req_valid),
        .ls_valid (bus.i_ls_req_valid),
        .gnt_if   (gnt_if),
        .gnt_ls   (gnt_ls)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rsp_fire  = (state == RSP) && bus.i_mem_rsp_valid;
        // A wash in the same cycle as the memory response still kills the fetch.
        if_rsp_d  = rsp_fire && owner_r == OWN_IF && !drop_r && !bus.i_flush;
        ls_rsp_d  = rsp_fire && owner_r == OWN_LS;
        unique case (state)
            IDLE:    if (gnt_if || gnt_ls)      state_nxt = REQ;
            REQ:     if (bus.i_mem_req_ready)   state_nxt = RSP;
            RSP:     if (bus.i_mem_rsp_valid)   state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // NOTE: hold registers are reset to zero so the memory-side fields read 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_r <= OWN_IF;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            wstrb_r <= '0;
        end else if (gnt_ls) begin
            owner_r <= OWN_LS;
            we_r    <= bus.i_ls_req_we;
            addr_r  <= bus.i_ls_req_addr;
            wdata_r <= bus.i_ls_req_wdata;
            wstrb_r <= bus.i_ls_req_wstrb;
        end else if (gnt_if) begin
            owner_r <= OWN_IF;
            we_r    <= 1'b0;
            addr_r  <= bus.i_if_req_addr;
            wdata_r <= '0;
            wstrb_r <= '0;
        end
    end

    // Flush only marks an in-flight fetch; the memory request itself is never withdrawn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_r <= 1'b0;
        end else if (rsp_fire) begin
            drop_r <= 1'b0;
        end else if (bus.i_flush && owner_r == OWN_IF && state != IDLE) begin
            drop_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_rsp_valid_r <= 1'b0;
            if_rsp_data_r  <= '0;
            ls_rsp_valid_r <= 1'b0;
            ls_rsp_data_r  <= '0;
        end else begin
            if_rsp_valid_r <= if_rsp_d;
            if_rsp_data_r  <= if_rsp_d ? bus.i_mem_rsp_data : '0;
            ls_rsp_valid_r <= ls_rsp_d;
            ls_rsp_data_r  <= (ls_rsp_d && !we_r) ? bus.i_mem_rsp_data : '0;
        end
    end

    assign bus.o_if_req_ready  = gnt_if;
    assign bus.o_ls_req_ready  = gnt_ls;
    assign bus.o_if_rsp_valid  = if_rsp_valid_r;
    assign bus.o_if_rsp_data   = if_rsp_data_r;
    assign bus.o_ls_rsp_valid  = ls_rsp_valid_r;
    assign bus.o_ls_rsp_data   = ls_rsp_data_r;
    assign bus.o_mem_req_valid = (state == REQ);
    assign bus.o_mem_req_we    = we_r;
    assign bus.o_mem_req_addr  = addr_r;
    assign bus.o_mem_req_wdata = wdata_r;
    assign bus.o_mem_req_wstrb = wstrb_r;
    assign bus.o_busy          = (state != IDLE);

endmodule

// File: tb/tb_core_c1_biu_arb.sv
// Randomised bench for core_c1_biu_arb against a transaction-level reference model.
// Honours C1_BIU_ARB_RR_EN for the expected arbitration order.
module tb_core_c1_biu_arb;
    import core_c1_biu_pkg::*;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int SW         = DW / 8;
    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_c1_biu_arb_if #(.AW(AW), .DW(DW)) bus ();

    core_c1_biu_arb #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: one outstanding transaction, tracked as a record plus progress flags.
    bit              busy_m, is_ls_m, req_pending, mem_accepted, drop_m, just_reset;
    int              rsp_wait, starve, grants_if, grants_ls;
    bit              last_ls = 1'b1;
    bit              t_we;
    logic [AW-1:0]   t_addr;
    logic [DW-1:0]   t_wdata;
    logic [SW-1:0]   t_wstrb;
    bit              exp_if_rsp, exp_ls_rsp;
    logic [DW-1:0]   exp_data;
    bit              if_taken, ls_taken;

    // Stimulus knobs (percent probabilities).
    int p_if, p_ls, p_rdy, p_flush, max_dly;

    task automatic clear_model();
        busy_m = 0; req_pending = 0; mem_accepted = 0; drop_m = 0;
        starve = 0; last_ls = 1; exp_if_rsp = 0; exp_ls_rsp = 0;
        if_taken = 0; ls_taken = 0;
    endtask

    task automatic step(input bit do_reset);
        bit g_if, g_ls, rsp_now;
        @(negedge clk);
        check("if_rsp_valid", 96'(bus.o_if_rsp_valid), 96'(exp_if_rsp));
        if (exp_if_rsp) check("if_rsp_data", 96'(bus.o_if_rsp_data), 96'(exp_data));
        check("ls_rsp_valid", 96'(bus.o_ls_rsp_valid), 96'(exp_ls_rsp));
        if (exp_ls_rsp) check("ls_rsp_data", 96'(bus.o_ls_rsp_data), 96'(exp_data));
        check("mem_req_valid", 96'(bus.o_mem_req_valid), 96'(req_pending));
        if (req_pending) begin
            check("mem_req_we_addr", 96'({bus.o_mem_req_we, bus.o_mem_req_addr}), 96'({t_we, t_addr}));
            check("mem_req_wdata_wstrb", 96'({bus.o_mem_req_wdata, bus.o_mem_req_wstrb}),
                  96'({t_wdata, t_wstrb}));
        end
        check("busy", 96'(bus.o_busy), 96'(busy_m));
        if (just_reset)
            check("reset_fields", 96'({bus.o_mem_req_we, bus.o_mem_req_addr, bus.o_mem_req_wstrb}), 96'(0));

        rsp_now = 0;
        bus.i_mem_rsp_valid = 1'b0;
        bus.i_mem_rsp_data  = $urandom;
        if (do_reset) begin
            rst_n = 1'b0;
            bus.i_if_req_valid  = 1'b0;
            bus.i_ls_req_valid  = 1'b0;
            bus.i_flush         = 1'b0;
            bus.i_mem_req_ready = 1'b0;
        end else begin
            rst_n = 1'b1;
            if (if_taken) bus.i_if_req_valid = 1'b0;
            if (ls_taken) bus.i_ls_req_valid = 1'b0;
            if (!bus.i_if_req_valid && $urandom_range(99) < p_if) begin
                bus.i_if_req_valid = 1'b1;
                bus.i_if_req_addr  = $urandom & 32'hffff_fffc;
            end
            if (!bus.i_ls_req_valid && $urandom_range(99) < p_ls) begin
                bus.i_ls_req_valid = 1'b1;
                bus.i_ls_req_we    = 1'($urandom_range(1));
                bus.i_ls_req_addr  = $urandom;
                bus.i_ls_req_wdata = $urandom;
                bus.i_ls_req_wstrb = SW'($urandom_range(1, (1 << SW) - 1));
            end
            bus.i_flush         = ($urandom_range(99) < p_flush);
            bus.i_mem_req_ready = ($urandom_range(99) < p_rdy);
            if (mem_accepted) begin
                if (rsp_wait == 0) begin
                    rsp_now = 1;
                    bus.i_mem_rsp_valid = 1'b1;
                end else begin
                    rsp_wait--;
                end
            end else if (just_reset || (!busy_m && $urandom_range(99) < 10)) begin
                bus.i_mem_rsp_valid = 1'b1;   // stray response, must be ignored
            end
        end
        just_reset = 0;
        if_taken = 0;
        ls_taken = 0;
        #1;

        g_if = 0;
        g_ls = 0;
        if (!do_reset && !busy_m) begin
`ifdef C1_BIU_ARB_RR_EN
            g_if = bus.i_if_req_valid && (last_ls || !bus.i_ls_req_valid);
            g_ls = bus.i_ls_req_valid && !g_if;
`else
            g_ls = bus.i_ls_req_valid && !(bus.i_if_req_valid && starve >= STARVE_MAX);
            g_if = bus.i_if_req_valid && !g_ls;
`endif
        end
        check("req_ready", 96'({bus.o_if_req_ready, bus.o_ls_req_ready}), 96'({g_if, g_ls}));

        exp_if_rsp = 0;
        exp_ls_rsp = 0;
        if (do_reset) begin
            clear_model();
            just_reset = 1;
        end else begin
            if (busy_m && !is_ls_m && bus.i_flush) drop_m = 1;
            if (rsp_now) begin
                busy_m       = 0;
                mem_accepted = 0;
                exp_if_rsp   = !is_ls_m && !drop_m;
                exp_ls_rsp   = is_ls_m;
                exp_data     = (is_ls_m && t_we) ? '0 : bus.i_mem_rsp_data;
            end else if (req_pending && bus.i_mem_req_ready) begin
                req_pending  = 0;
                mem_accepted = 1;
                rsp_wait     = $urandom_range(max_dly);
            end
            if (g_if || g_ls) begin
                busy_m      = 1;
                req_pending = 1;
                drop_m      = 0;
                is_ls_m     = g_ls;
                last_ls     = g_ls;
                t_we        = g_ls ? bus.i_ls_req_we    : 1'b0;
                t_addr      = g_ls ? bus.i_ls_req_addr  : bus.i_if_req_addr;
                t_wdata     = g_ls ? bus.i_ls_req_wdata : '0;
                t_wstrb     = g_ls ? bus.i_ls_req_wstrb : '0;
                if_taken    = g_if;
                ls_taken    = g_ls;
                if (g_if) grants_if++;
                else      grants_ls++;
                if (g_if) starve = 0;
                else if (bus.i_if_req_valid && starve < STARVE_MAX) starve++;
            end
        end
    endtask

    initial begin
        bus.i_flush = 1'b0;
        bus.i_if_req_valid = 1'b0; bus.i_if_req_addr = '0;
        bus.i_ls_req_valid = 1'b0; bus.i_ls_req_we = 1'b0; bus.i_ls_req_addr = '0;
        bus.i_ls_req_wdata = '0;   bus.i_ls_req_wstrb = '0;
        bus.i_mem_req_ready = 1'b0; bus.i_mem_rsp_valid = 1'b0; bus.i_mem_rsp_data = '0;
        clear_model();
        p_if = 0; p_ls = 0; p_rdy = 100; p_flush = 0; max_dly = 0;

        step(1);
        step(1);

        // IF alone with a zero-wait memory: fixed request/response latency.
        p_if = 100;
        repeat (20) step(0);
        check("if_only_grants", 96'(grants_ls), 96'(0));

        // Both requesters always valid: starvation guard / round-robin ordering.
        p_ls = 100;
        repeat (80) step(0);

        // Random traffic with washes, back-pressure and response delay.
        p_if = 60; p_ls = 60; p_rdy = 50; p_flush = 15; max_dly = 3;
        repeat (1500) step(0);

        // Long memory stalls hold the request fields.
        p_rdy = 12;
        repeat (400) step(0);

        // Reset while waiting for a response, then resume.
        p_rdy = 100; max_dly = 4;
        for (int i = 0; i < 200 && !mem_accepted; i++) step(0);
        check("reached_rsp_before_reset", 96'(mem_accepted), 96'(1));
        step(1);
        p_rdy = 50; max_dly = 2;
        repeat (300) step(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
